// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: md_op encoding, datapath width and md latencies.
`timescale 1ns/1ps
package mips_defs;

  localparam int WORD = 32;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  // True for the four ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// Combinational {hi,lo} result for mult/multu/div/divu, plus a divide-by-zero flag.
`timescale 1ns/1ps
module md_compute
  import mips_defs::*;
(
  input  logic [2:0]        md_op,
  input  logic [WORD-1:0]   a,
  input  logic [WORD-1:0]   b,
  output logic [2*WORD-1:0] result,
  output logic              div_by_zero
);

  logic              is_signed;
  logic [WORD-1:0]   dividend;
  logic [WORD-1:0]   divisor;
  logic [WORD-1:0]   uquot;
  logic [WORD-1:0]   urem;
  logic [WORD-1:0]   quot;
  logic [WORD-1:0]   rem;
  logic [2*WORD-1:0] a_sext;
  logic [2*WORD-1:0] b_sext;
  logic [2*WORD-1:0] a_zext;
  logic [2*WORD-1:0] b_zext;

  // Signed division works on magnitudes and fixes signs afterwards; the
  // 0x80000000 / -1 case falls out naturally as quotient 0x80000000, rem 0.
  always_comb begin
    is_signed   = (md_op == MD_DIV);
    div_by_zero = (b == '0);
    a_sext      = {{WORD{a[WORD-1]}}, a};
    b_sext      = {{WORD{b[WORD-1]}}, b};
    a_zext      = {{WORD{1'b0}}, a};
    b_zext      = {{WORD{1'b0}}, b};
    dividend    = (is_signed && a[WORD-1]) ? (~a + 1'b1) : a;
    divisor     = (is_signed && b[WORD-1]) ? (~b + 1'b1) : b;
    uquot       = '0;
    urem        = '0;
    if (!div_by_zero) begin
      uquot = dividend / divisor;
      urem  = dividend % divisor;
    end
    quot = (is_signed && (a[WORD-1] ^ b[WORD-1])) ? (~uquot + 1'b1) : uquot;
    rem  = (is_signed && a[WORD-1]) ? (~urem + 1'b1) : urem;
    result = '0;
    case (md_op)
      MD_MULT:         result = a_sext * b_sext;
      MD_MULTU:        result = a_zext * b_zext;
      MD_DIV, MD_DIVU: result = {rem, quot};
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: captures a result at start, holds Busy for a
// fixed latency, then commits to the architectural HI/LO registers.
`timescale 1ns/1ps
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      md_op,
  input  logic [WORD-1:0] A,
  input  logic [WORD-1:0] B,
  output logic            Busy,
  output logic [WORD-1:0] HI,
  output logic [WORD-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WORD-1:0]   hi_q, hi_d;
  logic [WORD-1:0]   lo_q, lo_d;
  logic [WORD-1:0]   pend_hi_q, pend_hi_d;
  logic [WORD-1:0]   pend_lo_q, pend_lo_d;
  logic              pend_valid_q, pend_valid_d;
  logic [2*WORD-1:0] comp_result;
  logic              comp_div_zero;

  md_compute u_compute (
    .md_op       (md_op),
    .a           (A),
    .b           (B),
    .result      (comp_result),
    .div_by_zero (comp_div_zero)
  );

  // Start, countdown, commit and MTHI/MTLO; any op seen while busy is dropped.
  always_comb begin
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && pend_valid_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (is_md_start(md_op)) begin
      pend_hi_d    = comp_result[2*WORD-1:WORD];
      pend_lo_d    = comp_result[WORD-1:0];
      pend_valid_d = !(((md_op == MD_DIV) || (md_op == MD_DIVU)) && comp_div_zero);
      cnt_d        = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                     CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (md_op == MD_MTHI) begin
      hi_d = A;
    end else if (md_op == MD_MTLO) begin
      lo_d = A;
    end
    busy_d = (cnt_d != '0);
  end

  // State registers with synchronous reset that also aborts an in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
`timescale 1ns/1ps
module tb_mult_div_unit;
  import mips_defs::*;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int check_count = 0;
  int pass_count  = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one op for a single cycle, then counts Busy-high cycles (bounded).
  // Returns at a negedge with Busy low, and flags any HI/LO change while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output bit held);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = HI; lo0 = LO;
    md_op = op; A = a; B = b;
    @(negedge clk);
    md_op = MD_NONE;
    busy_cycles = 0;
    held = 1'b1;
    while (Busy === 1'b1 && busy_cycles < 50) begin
      if (HI !== hi0 || LO !== lo0) held = 1'b0;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_count++;
    if ({Busy, HI, LO} !== 65'd0) $display("[TB] FAIL reset_init: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    else pass_count++;
    md_op = MD_MTHI; A = 32'h1234;
    @(negedge clk);
    md_op = MD_MTLO; A = 32'h5678;
    @(negedge clk);
    md_op = MD_MULT; A = 32'hFFFFFFFF; B = 32'd2;
    @(negedge clk);
    md_op = MD_NONE;
    check_count++;
    if ({Busy, HI, LO} !== {1'b1, 32'h1234, 32'h5678}) $display("[TB] FAIL reset_pre: got Busy=%b HI=%h LO=%h, want 1/1234/5678", Busy, HI, LO);
    else pass_count++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_count++;
    if ({Busy, HI, LO} !== 65'd0) $display("[TB] FAIL reset_abort: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    else pass_count++;
    repeat (8) @(negedge clk);
    check_count++;
    if ({Busy, HI, LO} !== 65'd0) $display("[TB] FAIL reset_no_commit: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
    else pass_count++;
  endtask

  task automatic test_mult();
    int n; bit held;
    run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, n, held);
    check_count++;
    if (n != 5) $display("[TB] FAIL mult_busy: got %0d cycles, want 5", n);
    else pass_count++;
    check_count++;
    if (!held) $display("[TB] FAIL mult_hold: HI/LO changed during busy, want held");
    else pass_count++;
    check_count++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFE) $display("[TB] FAIL mult_result: got HI=%h LO=%h, want FFFFFFFF/FFFFFFFE", HI, LO);
    else pass_count++;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, n, held);
    check_count++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFF1) $display("[TB] FAIL mult_neg: got HI=%h LO=%h, want FFFFFFFF/FFFFFFF1", HI, LO);
    else pass_count++;
  endtask

  task automatic test_unsigned();
    int n; bit held;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, n, held);
    check_count++;
    if (n != 5) $display("[TB] FAIL multu_busy: got %0d cycles, want 5", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== 64'h00000001_FFFFFFFE) $display("[TB] FAIL multu_result: got HI=%h LO=%h, want 00000001/FFFFFFFE", HI, LO);
    else pass_count++;
    run_op(MD_DIVU, 32'd100, 32'd7, n, held);
    check_count++;
    if (n != 10) $display("[TB] FAIL divu_busy: got %0d cycles, want 10", n);
    else pass_count++;
    check_count++;
    if (!held) $display("[TB] FAIL divu_hold: HI/LO changed during busy, want held");
    else pass_count++;
    check_count++;
    if ({HI, LO} !== {32'd2, 32'd14}) $display("[TB] FAIL divu_result: got HI=%h LO=%h, want 2/14", HI, LO);
    else pass_count++;
    run_op(MD_DIVU, 32'hFFFFFFF9, 32'd2, n, held);
    check_count++;
    if ({HI, LO} !== {32'd1, 32'h7FFFFFFC}) $display("[TB] FAIL divu_big: got HI=%h LO=%h, want 1/7FFFFFFC", HI, LO);
    else pass_count++;
  endtask

  task automatic test_div_signed();
    int n; bit held;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, n, held);
    check_count++;
    if (n != 10) $display("[TB] FAIL div_busy: got %0d cycles, want 10", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) $display("[TB] FAIL div_neg_dividend: got HI=%h LO=%h, want FFFFFFFF/FFFFFFFD", HI, LO);
    else pass_count++;
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, n, held);
    check_count++;
    if ({HI, LO} !== 64'h00000001_FFFFFFFD) $display("[TB] FAIL div_neg_divisor: got HI=%h LO=%h, want 00000001/FFFFFFFD", HI, LO);
    else pass_count++;
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n, held);
    check_count++;
    if ({HI, LO} !== 64'h00000000_80000000) $display("[TB] FAIL div_overflow: got HI=%h LO=%h, want 00000000/80000000", HI, LO);
    else pass_count++;
  endtask

  task automatic test_div_zero();
    int n; bit held;
    run_op(MD_MTHI, 32'h11, 32'd0, n, held);
    run_op(MD_MTLO, 32'h22, 32'd0, n, held);
    check_count++;
    if ({Busy, HI, LO} !== {1'b0, 32'h11, 32'h22}) $display("[TB] FAIL mt_setup: got Busy=%b HI=%h LO=%h, want 0/11/22", Busy, HI, LO);
    else pass_count++;
    run_op(MD_DIV, 32'd5, 32'd0, n, held);
    check_count++;
    if (n != 10) $display("[TB] FAIL divzero_busy: got %0d cycles, want 10", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== {32'h11, 32'h22}) $display("[TB] FAIL divzero_keep: got HI=%h LO=%h, want 11/22", HI, LO);
    else pass_count++;
    run_op(MD_DIVU, 32'd9, 32'd0, n, held);
    check_count++;
    if ({HI, LO} !== {32'h11, 32'h22}) $display("[TB] FAIL divuzero_keep: got HI=%h LO=%h, want 11/22", HI, LO);
    else pass_count++;
  endtask

  task automatic test_ignore_and_mt();
    int n;
    @(negedge clk);
    md_op = MD_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    md_op = MD_MTLO; A = 32'h55;
    @(negedge clk);
    md_op = MD_MULT; A = 32'd7; B = 32'd7;
    @(negedge clk);
    md_op = MD_NONE;
    n = 3;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_count++;
    if (n != 6) $display("[TB] FAIL ignore_busy: got Busy low after %0d cycles, want 6", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== {32'd0, 32'd12}) $display("[TB] FAIL ignore_result: got HI=%h LO=%h, want 0/C", HI, LO);
    else pass_count++;
    md_op = MD_MTHI; A = 32'hABCD;
    @(negedge clk);
    md_op = MD_NONE;
    check_count++;
    if ({Busy, HI, LO} !== {1'b0, 32'hABCD, 32'd12}) $display("[TB] FAIL mthi: got Busy=%b HI=%h LO=%h, want 0/ABCD/C", Busy, HI, LO);
    else pass_count++;
    md_op = MD_NONE + 3'd7; A = 32'hDEAD;
    @(negedge clk);
    md_op = MD_NONE;
    check_count++;
    if ({Busy, HI, LO} !== {1'b0, 32'hABCD, 32'd12}) $display("[TB] FAIL reserved_op: got Busy=%b HI=%h LO=%h, want 0/ABCD/C", Busy, HI, LO);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    md_op = MD_MULT; A = 32'd2; B = 32'd3;
    @(negedge clk);
    md_op = MD_DIVU; A = 32'd9; B = 32'd2;
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_count++;
    if (n != 5) $display("[TB] FAIL b2b_first_busy: got %0d cycles, want 5", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== {32'd0, 32'd6}) $display("[TB] FAIL b2b_first_result: got HI=%h LO=%h, want 0/6", HI, LO);
    else pass_count++;
    @(negedge clk);
    md_op = MD_NONE;
    check_count++;
    if (Busy !== 1'b1) $display("[TB] FAIL b2b_second_start: got Busy=%b, want 1", Busy);
    else pass_count++;
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_count++;
    if (n != 10) $display("[TB] FAIL b2b_second_busy: got %0d cycles, want 10", n);
    else pass_count++;
    check_count++;
    if ({HI, LO} !== {32'd1, 32'd4}) $display("[TB] FAIL b2b_second_result: got HI=%h LO=%h, want 1/4", HI, LO);
    else pass_count++;
  endtask

  // Scenario sequence, starting from a two-cycle reset.
  initial begin
    reset = 1'b1;
    md_op = MD_NONE;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult();
    test_unsigned();
    test_div_signed();
    test_div_zero();
    test_ignore_and_mt();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
